// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the UART slave port.
// The owner keeps the grant while cyc is high; a watchdog errors out stalled strobes.
module uart_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

  logic [1:0] state;
  logic       last;
  logic [7:0] wdog;

  logic req0, req1;
  logic own0, own1, owned;
  logic own_cyc, own_stb;
  logic timeout_hit, kill;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own0    = (state == S_OWN0);
  assign own1    = (state == S_OWN1);
  assign owned   = own0 | own1;
  assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own1 ? m1_stb_i : m0_stb_i;

  // A late ack in the limit cycle still completes the transfer, so the
  // strobe is only withdrawn when the error is actually raised.
  assign timeout_hit = owned && (wdog == WDOG_LIMIT);
  assign kill        = timeout_hit & ~s_ack_i;

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
    if (kill) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & kill;
  assign m1_err_o = own1 & kill;
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_dat_o = own1 ? s_dat_i : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wdog <= '0;
          // On a tie the master that did not own the bus last time wins.
          if (req0 && (!req1 || last)) begin
            state <= S_OWN0;
            last  <= 1'b0;
          end else if (req1) begin
            state <= S_OWN1;
            last  <= 1'b1;
          end
        end
        S_OWN0, S_OWN1: begin
          if (kill || !own_cyc) begin
            state <= S_IDLE;
            wdog  <= '0;
          end else if (own_stb && !s_ack_i) begin
            wdog <= wdog + 8'd1;
          end else begin
            wdog <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_wb_arbiter.md
# uart_wb_arbiter

Two-master Wishbone arbiter that shares the single UART Wishbone slave port inside the user project area. Master 0 is the management SoC Wishbone bus (wbs_* from the wrapper). Master 1 is a secondary on-chip requester, such as an LA-driven test master or a future DMA engine. The block sits between both masters and the uart instance, grants one master at a time with round-robin fairness, and bounds every stalled transfer with a watchdog that returns an error.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles a granted strobe may wait for slave ack (1..255)

Ports (N ∈ {0,1}, one line per per-master signal pair):
- wb_clk_i  input  1  system clock; all state on rising edge
- wb_rst_i  input  1  asynchronous, active-high reset
- mN_cyc_i  input  1  master N bus cycle
- mN_stb_i  input  1  master N strobe
- mN_we_i  input  1  master N write enable
- mN_sel_i  input  DW/8  master N byte selects
- mN_adr_i  input  AW  master N address
- mN_dat_i  input  DW  master N write data
- mN_ack_o  output  1  ack to master N
- mN_err_o  output  1  timeout error to master N (1-cycle pulse)
- mN_dat_o  output  DW  read data to master N
- s_cyc_o  output  1  slave cycle
- s_stb_o  output  1  slave strobe
- s_we_o  output  1  slave write enable
- s_sel_o  output  DW/8  slave byte selects
- s_adr_o  output  AW  slave address
- s_dat_o  output  DW  slave write data
- s_ack_i  input  1  slave ack
- s_dat_i  input  DW  slave read data

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last (last granted master), wdog (8-bit counter).
- Request: reqN = mN_cyc_i & mN_stb_i.
- Transitions out of IDLE:
  - Only req0 → OWN0; only req1 → OWN1.
  - Both → the master ≠ last; last updates on entry.
- In OWNk, slave outputs are a combinational mux of master k's signals (s_cyc_o=mk_cyc_i, s_stb_o=mk_stb_i, etc.).
- In IDLE, all s_* outputs are 0.
- Return paths:
  - mk_ack_o = s_ack_i & (state==OWNk); mk_dat_o = s_dat_i when OWNk, else 0.
  - The non-owner sees ack=0, err=0 and dat_o=0 (wait state).
- Release: OWNk → IDLE on the cycle mk_cyc_i is sampled low. Grant is held across back-to-back transfers while cyc stays high (block/RMW cycles are not interrupted).
- Watchdog:
  - In OWNk with mk_stb_i=1 and s_ack_i=0, wdog increments. wdog clears on ack, on stb low, or in IDLE.
  - When wdog reaches TIMEOUT, the block pulses mk_err_o for one cycle, forces s_cyc_o/s_stb_o to 0 that cycle, and goes to IDLE.
  - The same master is not re-granted before the other master if the other is requesting (last=k).
- Reset: state=IDLE, last=1 (master 0 wins first tie), wdog=0. Every output reads 0, including mN_ack_o, mN_err_o, mN_dat_o and all s_*.

## Timing
- Grant latency: req sampled at edge E → state OWNk after E; s_stb_o visible in the cycle following E. Minimum latency is 1 cycle from request to slave strobe.
- The ack path is combinational: slave ack in cycle C reaches the owner in cycle C, so there is no added read latency.
- Release latency: cyc low sampled at edge E → IDLE after E. The other master's pending request is sampled at the next edge, giving 1 idle cycle between owners.
- Simultaneous release and new request: decision is made only in IDLE, so no same-cycle handover.
- Error: mk_err_o is asserted in the cycle wdog==TIMEOUT. Ack and error are never both asserted. If ack arrives on that same cycle, ack wins, wdog clears and no error is raised.
- Reset asserted mid-transfer: s_cyc_o/s_stb_o drop asynchronously; no ack or err is issued.

## Test plan
- Single read: m0 reads adr 0x3000_0000; slave acks 2 cycles after strobe with 0xA5 → m0_dat_o=0xA5 with m0_ack_o=1 in the ack cycle; m1_ack_o stays 0; state returns to IDLE one cycle after m0_cyc_i drops.
- Tie after reset: m0 and m1 request in the same cycle → m0 served first. m1 is granted exactly 1 idle cycle after m0 releases and its write data 0x55 appears on s_dat_o.
- Round-robin: both masters request continuously for 4 transactions → grant order 0,1,0,1.
- Held cycle: m1 keeps cyc high across two strobes (write 0x11, then read) → m0 stays stalled with no ack until m1 drops cyc.
- Timeout (TIMEOUT=8): m0 strobes and the slave never acks → m0_err_o pulses exactly 1 cycle, 8 cycles after strobe; s_cyc_o falls; the pending m1 request is granted next.
- Mid-transfer reset: assert wb_rst_i during an OWN1 strobe → s_cyc_o and s_stb_o are 0 before the next clock edge. After release, the first tie grants m0.
